// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared state encoding and metric width helpers for the partition sweep
package sweep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_EMIT,
        ST_DONE
    } sweep_state_e;

    localparam int DEF_NUM_PI = 8;
    localparam int DEF_NUM_PO = 6;

    // Settle counter holds 1..15
    localparam int CNT_W = 4;

    // One extra bit covers the 2^NUM_PI mismatching-vector case
    function automatic int err_count_width(input int num_pi);
        return num_pi + 1;
    endfunction

    // Headroom for up to 7 differing bits per vector over a full sweep
    function automatic int ham_sum_width(input int num_pi);
        return num_pi + 3;
    endfunction

    // Enough bits to hold a popcount of NUM_PO bits
    function automatic int ham_width(input int num_po);
        return $clog2(num_po + 1);
    endfunction

endpackage

// File: rtl/sweep_err_metric.sv
// rtl/sweep_err_metric.sv - combinational Hamming distance and absolute difference of two PO words
module sweep_err_metric
    import sweep_pkg::*;
#(
    parameter int  NUM_PO = DEF_NUM_PO,
    localparam int HAM_W  = ham_width(NUM_PO)
) (
    input  logic [NUM_PO-1:0] exact_po,
    input  logic [NUM_PO-1:0] approx_po,
    output logic [HAM_W-1:0]  ham,
    output logic [NUM_PO-1:0] abs_diff
);

    logic [NUM_PO-1:0] diff_bits;
    logic [NUM_PO:0]   wide_diff;

    // Popcount of the XOR, and |exact - approx| from a one-bit-wider signed difference
    always_comb begin
        diff_bits = exact_po ^ approx_po;
        ham       = '0;
        for (int i = 0; i < NUM_PO; i++) begin
            ham = ham + HAM_W'(diff_bits[i]);
        end
        wide_diff = {1'b0, exact_po} - {1'b0, approx_po};
        // A set sign bit means approx > exact; the magnitude always fits in NUM_PO bits
        if (wide_diff[NUM_PO]) begin
            abs_diff = ~wide_diff[NUM_PO-1:0] + NUM_PO'(1);
        end else begin
            abs_diff = wide_diff[NUM_PO-1:0];
        end
    end

endmodule

// File: rtl/partition_sweep_ctrl.sv
// rtl/partition_sweep_ctrl.sv - exhaustive input sweep of a partition pair with error metrics and row stream
module partition_sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int  NUM_PI = DEF_NUM_PI,
    parameter int  NUM_PO = DEF_NUM_PO,
    parameter int  SETTLE = 1,
    localparam int HAM_W  = ham_width(NUM_PO),
    localparam int ERR_W  = err_count_width(NUM_PI),
    localparam int HSUM_W = ham_sum_width(NUM_PI)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [NUM_PI-1:0] pi,
    input  logic [NUM_PO-1:0] exact_po,
    input  logic [NUM_PO-1:0] approx_po,
    output logic              row_valid,
    input  logic              row_ready,
    output logic [NUM_PI-1:0] row_idx,
    output logic [NUM_PO-1:0] row_data,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  err_count,
    output logic [HSUM_W-1:0] ham_sum,
    output logic [HAM_W-1:0]  max_ham,
    output logic [NUM_PO-1:0] max_abs_err
);

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);

    sweep_state_e      state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [NUM_PI-1:0] pi_q;
    logic [NUM_PI-1:0] row_idx_q;
    logic [NUM_PO-1:0] row_data_q;
    logic              row_valid_q;
    logic              busy_q;
    logic              done_q;
    logic [ERR_W-1:0]  err_count_q, err_count_d;
    logic [HSUM_W-1:0] ham_sum_q, ham_sum_d;
    logic [HAM_W-1:0]  max_ham_q, max_ham_d;
    logic [NUM_PO-1:0] max_abs_q, max_abs_d;

    logic [HAM_W-1:0]  ham_w;
    logic [NUM_PO-1:0] abs_w;

    sweep_err_metric #(.NUM_PO(NUM_PO)) u_metric (
        .exact_po  (exact_po),
        .approx_po (approx_po),
        .ham       (ham_w),
        .abs_diff  (abs_w)
    );

    // Metric values to load on a capture cycle
    always_comb begin
        err_count_d = err_count_q + {{(ERR_W-1){1'b0}}, (ham_w != '0)};
        ham_sum_d   = ham_sum_q + HSUM_W'(ham_w);
        max_ham_d   = (ham_w > max_ham_q) ? ham_w : max_ham_q;
        max_abs_d   = (abs_w > max_abs_q) ? abs_w : max_abs_q;
    end

    // Sweep sequencer: drive vector, wait settle, capture, emit row, advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pi_q        <= '0;
            row_idx_q   <= '0;
            row_data_q  <= '0;
            row_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_count_q <= '0;
            ham_sum_q   <= '0;
            max_ham_q   <= '0;
            max_abs_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Abort beats a simultaneous start
                    if (start && !abort) begin
                        err_count_q <= '0;
                        ham_sum_q   <= '0;
                        max_ham_q   <= '0;
                        max_abs_q   <= '0;
                        pi_q        <= '0;
                        cnt_q       <= SETTLE_LD;
                        busy_q      <= 1'b1;
                        state_q     <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        row_data_q  <= approx_po;
                        row_idx_q   <= pi_q;
                        err_count_q <= err_count_d;
                        ham_sum_q   <= ham_sum_d;
                        max_ham_q   <= max_ham_d;
                        max_abs_q   <= max_abs_d;
                        row_valid_q <= 1'b1;
                        state_q     <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (abort) begin
                        row_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else if (row_ready) begin
                        row_valid_q <= 1'b0;
                        // The all-ones vector ends the sweep, so pi never wraps
                        if (&pi_q) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            pi_q    <= pi_q + NUM_PI'(1);
                            cnt_q   <= SETTLE_LD;
                            state_q <= ST_SETTLE;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    row_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign pi          = pi_q;
    assign row_valid   = row_valid_q;
    assign row_idx     = row_idx_q;
    assign row_data    = row_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_count   = err_count_q;
    assign ham_sum     = ham_sum_q;
    assign max_ham     = max_ham_q;
    assign max_abs_err = max_abs_q;

endmodule

// File: tb/tb_partition_sweep_ctrl.sv
// tb/tb_partition_sweep_ctrl.sv - self-checking bench for partition_sweep_ctrl
module tb_partition_sweep_ctrl;

    localparam int NV = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        row_ready;
    logic [7:0]  pi;
    logic [5:0]  exact_po;
    logic [5:0]  approx_po;
    logic        row_valid;
    logic [7:0]  row_idx;
    logic [5:0]  row_data;
    logic        busy;
    logic        done;
    logic [8:0]  err_count;
    logic [10:0] ham_sum;
    logic [2:0]  max_ham;
    logic [5:0]  max_abs_err;

    int n_chk = 0;
    int n_fail = 0;
    int mode = 0;
    int n_rows, row_bad, busy_cnt, done_cnt;
    logic [5:0] ex_tab [NV];
    logic [5:0] ap_tab [NV];

    typedef struct {
        int mode;
        bit rnd_ready;
        int stall_idx;
        int stall_len;
        int exp_err;
        int exp_ham;
        int exp_mh;
        int exp_ma;
        int exp_len;
    } vec_t;
    vec_t vec [5];

    partition_sweep_ctrl #(.NUM_PI(8), .NUM_PO(6), .SETTLE(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .pi          (pi),
        .exact_po    (exact_po),
        .approx_po   (approx_po),
        .row_valid   (row_valid),
        .row_ready   (row_ready),
        .row_idx     (row_idx),
        .row_data    (row_data),
        .busy        (busy),
        .done        (done),
        .err_count   (err_count),
        .ham_sum     (ham_sum),
        .max_ham     (max_ham),
        .max_abs_err (max_abs_err)
    );

    always #5 clk = ~clk;

    // Partition pair stand-in: responds to pi according to the current mode
    always_comb begin
        case (mode)
            0: begin
                exact_po  = {2'b0, pi[3:0]};
                approx_po = exact_po;
            end
            1: begin
                exact_po  = {2'b0, pi[3:0]};
                approx_po = exact_po ^ {5'b0, pi[0]};
            end
            default: begin
                exact_po  = ex_tab[pi];
                approx_po = ap_tab[pi];
            end
        endcase
    end

    function automatic int exact_of(input int m, input int v);
        if (m == 2) return int'(ex_tab[v]);
        return v % 16;
    endfunction

    function automatic int approx_of(input int m, input int v);
        if (m == 2) return int'(ap_tab[v]);
        if (m == 1) return (v % 16) ^ (v % 2);
        return v % 16;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: log any handshake about to happen, then step to just after the edge
    task automatic tick();
        if (row_valid === 1'b1 && row_ready === 1'b1) begin
            if (int'(row_idx) != n_rows || int'(row_data) != approx_of(mode, int'(row_idx))) row_bad++;
            n_rows++;
        end
        @(posedge clk);
        #1;
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) done_cnt++;
    endtask

    // Reference metrics over the whole input space
    task automatic model(output int err, output int ham, output int mh, output int ma);
        err = 0; ham = 0; mh = 0; ma = 0;
        for (int v = 0; v < NV; v++) begin
            int e, a, h, d;
            e = exact_of(mode, v);
            a = approx_of(mode, v);
            h = $countones(e ^ a);
            d = (e > a) ? e - a : a - e;
            if (h != 0) err++;
            ham += h;
            if (h > mh) mh = h;
            if (d > ma) ma = d;
        end
    endtask

    task automatic run_sweep(input int k);
        int t, stall_rem;
        bit stalled;
        logic [5:0] held;
        mode = vec[k].mode;
        if (mode == 2) begin
            for (int v = 0; v < NV; v++) begin
                ex_tab[v] = 6'($urandom);
                ap_tab[v] = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ex_tab[v];
            end
            model(vec[k].exp_err, vec[k].exp_ham, vec[k].exp_mh, vec[k].exp_ma);
        end
        n_rows = 0; row_bad = 0; busy_cnt = 0; done_cnt = 0;
        stall_rem = 0; stalled = 0; held = '0;
        row_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        t = 1;
        while (done_cnt == 0 && t < 3000) begin
            if (!stalled && vec[k].stall_len > 0 && row_valid && int'(row_idx) == vec[k].stall_idx) begin
                stalled = 1;
                stall_rem = vec[k].stall_len;
                held = row_data;
            end
            if (stall_rem > 0) row_ready = 1'b0;
            else if (vec[k].rnd_ready) row_ready = 1'($urandom_range(0, 1));
            else row_ready = 1'b1;
            tick();
            t++;
            if (stall_rem > 0) begin
                stall_rem--;
                check("stall_valid", row_valid, 1);
                check("stall_idx", row_idx, vec[k].stall_idx);
                check("stall_data", row_data, held);
                check("stall_pi", pi, vec[k].stall_idx);
            end
        end
        check("done_seen", done_cnt, 1);
        if (vec[k].exp_len > 0) begin
            check("done_cycle", t, vec[k].exp_len);
            check("busy_cycles", busy_cnt, vec[k].exp_len - 1);
        end
        check("row_count", n_rows, NV);
        check("row_order_data", row_bad, 0);
        check("err_count", err_count, vec[k].exp_err);
        check("ham_sum", ham_sum, vec[k].exp_ham);
        check("max_ham", max_ham, vec[k].exp_mh);
        check("max_abs_err", max_abs_err, vec[k].exp_ma);
        row_ready = 1'b1;
        tick();
        check("done_one_cycle", done, 0);
        check("idle_busy", busy, 0);
        check("err_held", err_count, vec[k].exp_err);
    endtask

    initial begin
        int t;
        vec[0] = '{0, 1'b0, -1, 0, 0,   0,   0, 0, 769};
        vec[1] = '{1, 1'b0, -1, 0, 128, 128, 1, 1, 769};
        vec[2] = '{1, 1'b0, 3,  5, 128, 128, 1, 1, 774};
        vec[3] = '{2, 1'b0, -1, 0, 0,   0,   0, 0, 769};
        vec[4] = '{2, 1'b1, -1, 0, 0,   0,   0, 0, -1};

        rst = 1'b1; start = 1'b0; abort = 1'b0; row_ready = 1'b0;
        n_rows = 0; row_bad = 0; busy_cnt = 0; done_cnt = 0;
        tick();
        tick();
        check("reset_outputs", {pi, row_idx, row_data, err_count, ham_sum, max_ham, max_abs_err}, 0);
        check("reset_flags", {row_valid, busy, done}, 0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < 5; k++) run_sweep(k);

        // Abort in SETTLE at vector 100
        mode = 1; row_ready = 1'b1; done_cnt = 0;
        start = 1'b1; tick(); start = 1'b0;
        t = 0;
        while (!(pi == 8'd100 && busy) && t < 1000) begin tick(); t++; end
        check("reach_vec100", pi, 100);
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", row_valid, 0);
        check("abort_pi_held", pi, 100);
        check("abort_err", err_count, 50);
        check("abort_ham", ham_sum, 50);
        tick(); tick(); tick();
        check("abort_no_done", done_cnt, 0);
        check("abort_err_held", err_count, 50);
        start = 1'b1; abort = 1'b1; tick();
        check("start_abort_busy", busy, 0);
        check("start_abort_err", err_count, 50);
        abort = 1'b0; tick(); start = 1'b0;
        check("restart_busy", busy, 1);
        check("restart_pi", pi, 0);
        check("restart_clear", {err_count, ham_sum, max_ham, max_abs_err}, 0);
        abort = 1'b1; tick(); abort = 1'b0;
        check("restart_abort", busy, 0);

        // Asynchronous reset while emitting row 40
        mode = 1; row_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        t = 0;
        while (!(row_valid && row_idx == 8'd40) && t < 1000) begin tick(); t++; end
        row_ready = 1'b0;
        check("pre_reset_err", err_count, 20);
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs", {pi, row_idx, row_data, err_count, ham_sum, max_ham, max_abs_err}, 0);
        check("async_reset_flags", {row_valid, busy, done}, 0);
        tick();
        rst = 1'b0; row_ready = 1'b1;
        tick();
        check("post_reset_valid", row_valid, 0);
        tick();
        check("post_reset_idle", {row_valid, busy, done}, 0);

        // start held high across a full sweep
        mode = 0; row_ready = 1'b1; done_cnt = 0; busy_cnt = 0; n_rows = 0; row_bad = 0;
        start = 1'b1;
        t = 0;
        while (done_cnt == 0 && t < 3000) begin tick(); t++; end
        check("held_done_cycle", t, 769);
        check("held_busy_cycles", busy_cnt, 768);
        tick();
        check("held_idle_gap", {busy, done}, 0);
        tick();
        check("held_resweep_busy", busy, 1);
        check("held_resweep_pi", pi, 0);
        start = 1'b0; abort = 1'b1; tick(); abort = 1'b0; tick();
        check("held_single_done", done_cnt, 1);
        check("held_rows", n_rows, NV);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
